// File: rtl/popcount_pkg.sv
// Shared widths and state encoding for the ternary popcount accumulator.
package popcount_pkg;

  function automatic int pc_width(input int n);
    return $clog2(n + 1);
  endfunction

  // One sign bit on top of the largest frame magnitude.
  function automatic int sum_width(input int n, input int b);
    return $clog2(n * b + 1) + 1;
  endfunction

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} pc_state_e;

endpackage

// File: rtl/popcount_tree.sv
// Exact combinational popcount as a balanced binary adder tree; the 2- and
// 3-input leaves reduce to half/full adders.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter int N = 25,
  localparam int CW = pc_width(N)
) (
  input  logic [N-1:0]  bits_i,
  output logic [CW-1:0] cnt_o
);

  if (N == 1) begin : g_leaf
    assign cnt_o = bits_i;
  end else begin : g_node
    localparam int NL = N / 2;
    localparam int NH = N - NL;
    logic [pc_width(NL)-1:0] lo;
    logic [pc_width(NH)-1:0] hi;

    popcount_tree #(.N(NL)) u_lo (.bits_i(bits_i[NL-1:0]), .cnt_o(lo));
    popcount_tree #(.N(NH)) u_hi (.bits_i(bits_i[N-1:NL]), .cnt_o(hi));

    assign cnt_o = CW'(lo) + CW'(hi);
  end

endmodule

// File: rtl/popcount_ternary_accum.sv
// Accumulates popcount(pos) - popcount(neg) over BEATS beats per frame and
// holds the signed sum plus a thresholded activation until consumed.
module popcount_ternary_accum
  import popcount_pkg::*;
#(
  parameter int CHUNK_W = 25,
  parameter int BEATS   = 4,
  parameter int SUM_W   = sum_width(CHUNK_W, BEATS),
  parameter int REG_PC  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_pos,
  input  logic [CHUNK_W-1:0] in_neg,
  input  logic               in_clear,
  input  logic [SUM_W-1:0]   thresh,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUM_W-1:0]   out_sum,
  output logic               out_act
);

  localparam int PCW   = pc_width(CHUNK_W);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  pc_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [SUM_W-1:0] acc_q, acc_d, sum_q, sum_d, acc_nxt, c_dext;
  logic                    act_q, act_d;
  logic                    hold, clr, take, pipe_blk;
  logic [CHUNK_W-1:0]      pos_m, neg_m;
  logic [PCW-1:0]          pc_pos, pc_neg;
  logic signed [PCW:0]     delta, c_delta;
  logic                    c_vld, c_first, c_last;

  assign hold     = (state_q == HOLD);
  assign clr      = in_clear & ~hold;
  assign in_ready = (~hold | out_ready) & ~pipe_blk;
  assign take     = in_valid & in_ready & ~clr;

  // Idle-cycle data may be X; keep it out of the adder trees entirely.
  assign pos_m = in_valid ? in_pos : '0;
  assign neg_m = in_valid ? in_neg : '0;

  popcount_tree #(.N(CHUNK_W)) u_pc_pos (.bits_i(pos_m), .cnt_o(pc_pos));
  popcount_tree #(.N(CHUNK_W)) u_pc_neg (.bits_i(neg_m), .cnt_o(pc_neg));

  assign delta = $signed({1'b0, pc_pos}) - $signed({1'b0, pc_neg});

  if (REG_PC != 0) begin : g_pipe
    logic                pv_q, pf_q, pl_q, stall;
    logic signed [PCW:0] pd_q;

    // A frame-final beat cannot land while the previous result is still held.
    assign stall    = pv_q & pl_q & hold & ~out_ready;
    assign pipe_blk = stall;
    assign c_vld    = pv_q & ~stall & ~clr;
    assign c_delta  = pd_q;
    assign c_first  = pf_q;
    assign c_last   = pl_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv_q <= 1'b0;
        pd_q <= '0;
        pf_q <= 1'b0;
        pl_q <= 1'b0;
      end else if (take) begin
        pv_q <= 1'b1;
        pd_q <= delta;
        pf_q <= (cnt_q == '0);
        pl_q <= (cnt_q == LAST);
      end else if (clr || !stall) begin
        pv_q <= 1'b0;
      end
    end
  end else begin : g_comb
    assign pipe_blk = 1'b0;
    assign c_vld    = take;
    assign c_delta  = delta;
    assign c_first  = (cnt_q == '0);
    assign c_last   = (cnt_q == LAST);
  end

  assign c_dext  = SUM_W'(c_delta);
  assign acc_nxt = (c_first ? '0 : acc_q) + c_dext;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    act_d   = act_q;
    if (clr)       cnt_d = '0;
    else if (take) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    if (c_vld) acc_d = acc_nxt;
    if (c_vld && c_last) begin
      state_d = HOLD;
      sum_d   = acc_nxt;
      act_d   = (acc_nxt >= $signed(thresh));
    end else if (hold && out_ready) begin
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      act_q   <= act_d;
    end
  end

  assign out_valid = hold;
  assign out_sum   = sum_q;
  assign out_act   = act_q;

endmodule

// File: tb/tb_popcount_ternary_accum.sv
// Bench: three configurations share one stimulus stream; each has its own
// frame-level reference model and result FIFO.
module tb_popcount_ternary_accum;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_clear, out_ready;
  logic [24:0] in_pos, in_neg;
  logic [7:0]  thr;
  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, act0, act1, act2;
  logic [7:0]  sum0, sum1;
  logic [5:0]  sum2;

  always #5 clk = ~clk;

  popcount_ternary_accum #(.CHUNK_W(25), .BEATS(4), .REG_PC(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_pos(in_pos),
    .in_neg(in_neg), .in_clear(in_clear), .thresh(thr), .out_valid(ov0),
    .out_ready(out_ready), .out_sum(sum0), .out_act(act0));
  popcount_ternary_accum #(.CHUNK_W(25), .BEATS(3), .REG_PC(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_pos(in_pos),
    .in_neg(in_neg), .in_clear(in_clear), .thresh(thr), .out_valid(ov1),
    .out_ready(out_ready), .out_sum(sum1), .out_act(act1));
  popcount_ternary_accum #(.CHUNK_W(25), .BEATS(1), .REG_PC(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_pos(in_pos),
    .in_neg(in_neg), .in_clear(in_clear), .thresh(thr[5:0]), .out_valid(ov2),
    .out_ready(out_ready), .out_sum(sum2), .out_act(act2));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state per DUT: beats-in-frame, running sum, result FIFO.
  int mcnt[3], macc[3], wp[3], rp[3], nres[3];
  int fs[3][32], fc[3][32];
  bit fa[3][32];
  bit pl[3], ovp[3];

  function automatic int nbeats(input int k);
    return (k == 0) ? 4 : (k == 1) ? 3 : 1;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int thr_of(input int k);
    logic signed [5:0] t6;
    logic signed [7:0] t8;
    t6 = thr[5:0];
    t8 = thr;
    return (k == 2) ? int'(t6) : int'(t8);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0; macc[k] = 0; wp[k] = 0; rp[k] = 0; pl[k] = 0; ovp[k] = 0;
    end
  endtask

  task automatic monitor();
    logic rdy[3], ov[3], ac[3];
    logic signed [31:0] sm[3];
    bit clr, acc;
    int d, idx;
    rdy[0] = rdy0; rdy[1] = rdy1; rdy[2] = rdy2;
    ov[0]  = ov0;  ov[1]  = ov1;  ov[2]  = ov2;
    ac[0]  = act0; ac[1]  = act1; ac[2]  = act2;
    sm[0]  = $signed(sum0); sm[1] = $signed(sum1); sm[2] = $signed(sum2);
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_in_ready", k), rdy[k], !ov[k] || out_ready);
      if (ov[k]) begin
        chk($sformatf("u%0d_pending", k), (wp[k] - rp[k]) > 0, 1);
        if (wp[k] > rp[k]) begin
          idx = rp[k] % 32;
          chk($sformatf("u%0d_sum", k), sm[k], fs[k][idx]);
          chk($sformatf("u%0d_act", k), ac[k], fa[k][idx]);
          if (!ovp[k]) chk($sformatf("u%0d_latency", k), cyc - fc[k][idx], lat(k));
          if (out_ready) begin rp[k]++; nres[k]++; end
        end
      end
      ovp[k] = ov[k];
      clr = in_clear && !ov[k];
      // With the registered stage, a frame-final beat taken last cycle is still in flight.
      if (clr && k != 0 && pl[k]) wp[k]--;
      pl[k] = 0;
      if (clr) mcnt[k] = 0;
      acc = in_valid && rdy[k] && !clr;
      if (acc) begin
        d = $countones(in_pos) - $countones(in_neg);
        macc[k] = (mcnt[k] == 0) ? d : macc[k] + d;
        mcnt[k]++;
        if (mcnt[k] == nbeats(k)) begin
          idx = wp[k] % 32;
          fs[k][idx] = macc[k];
          fa[k][idx] = (macc[k] >= thr_of(k));
          fc[k][idx] = cyc;
          wp[k]++;
          mcnt[k] = 0;
          pl[k] = 1;
        end
      end
    end
  endtask

  task automatic tick(output bit acc0);
    @(negedge clk);
    acc0 = in_valid && rdy0 && !(in_clear && !ov0);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [24:0] p, input logic [24:0] n);
    bit a;
    int t;
    in_valid = 1'b1; in_pos = p; in_neg = n; t = 0;
    do begin tick(a); t++; end while (!a && t < 50);
    chk("beat_accept", a, 1);
    in_valid = 1'b0; in_pos = 'x; in_neg = 'x;
  endtask

  task automatic pulse_reset();
    bit a;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", ov0, 0);
    chk("rst_async_out_sum", $signed(sum0), 0);
    chk("rst_async_in_ready", rdy0, 1);
    model_reset();
    tick(a);
    rst_n = 1'b1;
  endtask

  initial begin
    bit a;
    rst_n = 1'b0; in_valid = 1'b0; in_clear = 1'b0; out_ready = 1'b1;
    in_pos = '0; in_neg = '0; thr = 8'd50;
    for (int k = 0; k < 3; k++) nres[k] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", ov0, 0);
    chk("reset_out_sum", $signed(sum0), 0);
    chk("reset_out_act", act0, 0);
    chk("reset_in_ready", rdy0, 1);
    chk("reset_u1_out_valid", ov1, 0);
    rst_n = 1'b1;

    // All-ones frame: 100 >= 50, one-cycle pulse with out_ready high.
    for (int i = 0; i < 3; i++) beat(25'h1FFFFFF, 25'h0);
    chk("t1_not_early", ov0, 0);
    beat(25'h1FFFFFF, 25'h0);
    chk("t1_valid", ov0, 1);
    chk("t1_sum", $signed(sum0), 100);
    chk("t1_act", act0, 1);
    tick(a);
    chk("t1_pulse_end", ov0, 0);

    // Cancelling bits and a negative frame.
    thr = 8'd0;
    beat(25'h1FFFFFF, 25'h1FFFFFF);
    for (int i = 0; i < 3; i++) beat(25'h0, 25'h7);
    chk("t2_sum", $signed(sum0), -9);
    chk("t2_act", act0, 0);
    tick(a);

    // Threshold boundary: sum equal to thresh activates, one above does not.
    thr = 8'd5;
    beat(25'h1F, 25'h0);
    for (int i = 0; i < 3; i++) beat(25'h0, 25'h0);
    chk("t2b_eq_act", act0, 1);
    tick(a);
    thr = 8'd6;
    beat(25'h1F, 25'h0);
    for (int i = 0; i < 3; i++) beat(25'h0, 25'h0);
    chk("t2b_above_act", act0, 0);
    tick(a);

    // Back-pressure: result held for 5 cycles, thresh changes are ignored.
    thr = 8'd0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(25'h3, 25'h0);
    in_valid = 1'b1; in_pos = 25'h1; in_neg = 25'h0;
    for (int i = 0; i < 5; i++) begin
      tick(a);
      thr = 8'd100;
      chk("t3_no_accept", a, 0);
      chk("t3_in_ready", rdy0, 0);
      chk("t3_sum_stable", $signed(sum0), 8);
      chk("t3_act_stable", act0, 1);
    end
    out_ready = 1'b1;
    tick(a);
    chk("t3_release_accept", a, 1);
    for (int i = 0; i < 3; i++) beat(25'h1, 25'h0);
    chk("t3_next_sum", $signed(sum0), 4);
    chk("t3_next_act", act0, 0);
    tick(a);
    thr = 8'd0;

    // Clear mid-frame, including the beat presented alongside it.
    beat(25'h3FF, 25'h0);
    beat(25'h3FF, 25'h0);
    in_valid = 1'b1; in_pos = 25'h1FFFFFF; in_neg = 25'h0; in_clear = 1'b1;
    tick(a);
    in_clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) beat(25'h1, 25'h0);
    chk("t4_sum", $signed(sum0), 4);
    tick(a);

    // Asynchronous reset over a held result, then mid-frame.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(25'h7, 25'h0);
    chk("t5_held", ov0, 1);
    pulse_reset();
    out_ready = 1'b1;
    beat(25'h7, 25'h0);
    beat(25'h7, 25'h0);
    pulse_reset();
    for (int i = 0; i < 4; i++) beat(25'h7, 25'h0);
    chk("t5_sum", $signed(sum0), 12);
    chk("t5_act", act0, 1);
    tick(a);

    // Random streams with gaps on both sides.
    for (int seg = 0; seg < 4; seg++) begin
      thr = 8'($urandom_range(0, 40) - 20);
      for (int i = 0; i < 600; i++) begin
        in_valid = ($urandom_range(0, 9) < 7);
        if (in_valid) begin
          in_pos = $urandom_range(0, 1) ? 25'($urandom) : 25'($urandom & $urandom);
          in_neg = $urandom_range(0, 1) ? 25'($urandom) : 25'($urandom & $urandom);
        end else begin
          in_pos = 'x; in_neg = 'x;
        end
        out_ready = ($urandom_range(0, 9) < 6);
        tick(a);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) tick(a);
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_drained", k), wp[k] - rp[k], 0);
      chk($sformatf("u%0d_results_seen", k), nres[k] > 20, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_ternary_accum.md
Name: popcount_ternary_accum

Overview:
- Parametrised, sequential successor to the fixed 25-input exact popcount circuits.
- Each beat delivers a CHUNK_W-wide ternary chunk as positive and negative bit-planes. The block accumulates the signed sum of (ones in pos) minus (ones in neg) over BEATS beats, then emits the sum and a thresholded activation.
- Sits between the on-sensor input shifter and the printed-NN neuron output stage.
- Frames wider than one combinational popcount are processed over several cycles, with valid/ready flow control on both sides.

Parameters:
- CHUNK_W, 25, bits per beat (≥1).
- BEATS, 4, beats per frame (≥1).
- SUM_W, $clog2(CHUNK_W*BEATS+1)+1, signed width of sum and threshold (derived; do not override).
- REG_PC, 1, 1 = register the chunk popcounts (extra pipeline stage); 0 = popcount feeds the accumulator directly.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_pos  in  CHUNK_W  +1 weight bit-plane.
- in_neg  in  CHUNK_W  −1 weight bit-plane.
- in_clear  in  1  discard the partial frame, synchronous.
- thresh  in  SUM_W  signed activation threshold, sampled when out_valid rises.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  SUM_W  signed frame sum.
- out_act  out  1  1 when out_sum ≥ thresh (signed compare).

Behaviour:
- Reset (async assert, sync deassert by the integrator): state=ACCUM, beat_cnt=0, acc=0, pipe valid=0, out_valid=0, out_sum=0, out_act=0, in_ready=1 after deassert.
- Beat accepted when in_valid & in_ready.
- Per beat: delta = popcount(in_pos) − popcount(in_neg).
  - Popcounts are exact, CHUNK_W-wide, unsigned width $clog2(CHUNK_W+1).
  - A bit set in both planes cancels to 0.
- Accumulate: acc <= (beat_cnt==0 ? 0 : acc) + delta, sign-extended to SUM_W. Overflow is impossible by construction.
- beat_cnt increments per accepted beat. It wraps to 0 after BEATS−1 and the state goes to HOLD.
- States:
  - ACCUM: collecting beats; out_valid=0.
  - HOLD: out_valid=1; out_sum and out_act are stable and unchanged until out_ready.
  - HOLD & out_ready: go to ACCUM; out_valid falls the next cycle unless a new frame completes.
- in_ready:
  - REG_PC=0: in_ready = (state==ACCUM) | (state==HOLD & out_ready).
  - REG_PC=1: the popcount register forms one skid stage. in_ready is additionally low when that stage holds the last beat of a frame and state==HOLD & !out_ready.
  - Beats accepted in the cycle HOLD is released start a fresh frame (beat_cnt=0).
- Latency, last beat accepted to out_valid high: 1 cycle (REG_PC=0) or 2 cycles (REG_PC=1).
- Throughput: one beat per cycle sustained when out_ready=1. A frame of BEATS beats yields a result every BEATS cycles with no bubbles.
- out_act is computed once, from thresh, on the cycle HOLD is entered. Changes to thresh during HOLD are ignored.
- in_clear:
  - In ACCUM: beat_cnt=0, the accumulator is marked empty, and any in-flight pipe beat is dropped. A beat presented in the same cycle is also dropped.
  - In HOLD: no effect on the held result.
- Reset mid-frame: partial frame and held result are lost, and out_valid drops immediately (asynchronous).
- BEATS=1: every accepted beat produces a result.
- X on in_pos/in_neg when in_valid=0 must not propagate into acc.

Decomposition:
- Package popcount_pkg: localparam functions pc_width(n) = $clog2(n+1) and sum_width(n,b); typedef enum logic [0:0] {ACCUM, HOLD} pc_state_e.
- Sub-module popcount_tree: purely combinational, exact, parametrised by CHUNK_W. It is a balanced adder tree of full/half adders in the same structure as the existing exact popcount generators. It is instantiated twice, once for pos and once for neg.

Test Plan:
- Reset, then 4 beats with in_pos=all-1, in_neg=0, thresh=50 → out_sum=100, out_act=1, out_valid high 1 cycle (REG_PC=0) after the 4th beat.
- Beats pos=0x1FFFFFF, neg=0x1FFFFFF, then 3 beats of pos=0, neg=0x0000007, thresh=0 → out_sum=−9, out_act=0.
- Hold out_ready=0 for 5 cycles after a frame completes → in_ready=0 during that time, out_sum stable; release → next frame accepted on the same cycle, no lost beats.
- Two beats (+10 each), then in_clear, then 4 beats of +1 → out_sum=4.
- rst_n pulsed low after beat 2 → out_valid=0 immediately; next full frame of +3/beat → out_sum=12.
- Randomised streams with random in_valid/out_ready gaps, BEATS∈{1,3,4}, REG_PC∈{0,1} → every result matches the golden signed sum; result order preserved.
